frequency_meter: RTL

//  Measures the frequency of an asynchronous test signal against the system clock.

---
 rtl/frequency_meter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/frequency_meter.sv
// frequency_meter
//   Counts rising edges of an asynchronous test signal over a fixed gate window of
//   GATE_CYCLES clocks, then converts the count to 5 BCD digits with an iterative
//   double dabble (one bit per clock).
//
// Parameters
//   GATE_CYCLES  gate window length in clk cycles
//   CNT_W        edge counter / result width (2..16); the counter saturates at 2^CNT_W-1
//   SYNC_STAGES  synchronizer depth on sig_in (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   block enable; low aborts any measurement without a result
//   start     in   single-shot request, honoured in idle only
//   cont      in   continuous mode, re-arms after every result
//   sig_in    in   asynchronous signal under test
//   busy      out  high while gating or converting
//   freq_cnt  out  last completed edge count
//   bcd       out  last completed count as 5 BCD digits, [19:16] most significant
//   ovf       out  last completed count saturated
//   valid     out  one-cycle pulse when freq_cnt, bcd and ovf update
module frequency_meter #(
   parameter int unsigned GATE_CYCLES = 50000,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             cont,
   input  logic             sig_in,
   output logic             busy,
   output logic [CNT_W-1:0] freq_cnt,
   output logic [19:0]      bcd,
   output logic             ovf,
   output logic             valid
);

   localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned CONV_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CNT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {StIdle, StGate, StConvert, StDone} state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_int_q;
   logic [GATE_W-1:0]      gate_q;
   logic [CONV_W-1:0]      conv_q;
   logic [CNT_W-1:0]       dd_bin_q;
   logic [19:0]            dd_bcd_q;

   logic             edge_det;
   logic             arm;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf_inc;
   logic [19:0]      dd_adj;
   logic [19:0]      dd_bcd_d;

   assign edge_det = sync_q[SYNC_STAGES-1] & ~edge_q;

   // A new window starts from idle on any request, or straight out of done in cont mode.
   assign arm = en & (((state_q == StIdle) & (start | cont)) | ((state_q == StDone) & cont));

   // Saturating edge count; ovf_int only flags an edge that arrived while already at max.
   always_comb begin
      cnt_inc = cnt_q;
      ovf_inc = ovf_int_q;
      if (edge_det) begin
         if (cnt_q == CNT_MAX) begin
            ovf_inc = 1'b1;
         end else begin
            cnt_inc = cnt_q + CNT_W'(1);
         end
      end
   end

   // One double dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   always_comb begin
      dd_adj = dd_bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (dd_bcd_q[4*i +: 4] >= 4'd5) begin
            dd_adj[4*i +: 4] = dd_bcd_q[4*i +: 4] + 4'd3;
         end
      end
      dd_bcd_d = {dd_adj[18:0], dd_bin_q[CNT_W-1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sync_q    <= '0;
         edge_q    <= 1'b0;
         cnt_q     <= '0;
         ovf_int_q <= 1'b0;
         gate_q    <= '0;
         conv_q    <= '0;
         dd_bin_q  <= '0;
         dd_bcd_q  <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         freq_cnt  <= '0;
         bcd       <= '0;
         ovf       <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         edge_q <= sync_q[SYNC_STAGES-1];
         valid  <= 1'b0;

         if (!en) begin
            // Abort: results from the previous measurement are left untouched.
            state_q <= StIdle;
            busy    <= 1'b0;
         end else if (arm) begin
            state_q   <= StGate;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            gate_q    <= '0;
            busy      <= 1'b1;
         end else begin
            case (state_q)
               StGate: begin
                  cnt_q     <= cnt_inc;
                  ovf_int_q <= ovf_inc;
                  gate_q    <= gate_q + GATE_W'(1);
                  if (gate_q == GATE_LAST) begin
                     // The last gate cycle's edge is included in the captured value.
                     state_q  <= StConvert;
                     dd_bin_q <= cnt_inc;
                     dd_bcd_q <= '0;
                     conv_q   <= '0;
                  end
               end
               StConvert: begin
                  dd_bcd_q <= dd_bcd_d;
                  dd_bin_q <= {dd_bin_q[CNT_W-2:0], 1'b0};
                  conv_q   <= conv_q + CONV_W'(1);
                  if (conv_q == CONV_LAST) begin
                     state_q  <= StDone;
                     busy     <= 1'b0;
                     valid    <= 1'b1;
                     freq_cnt <= cnt_q;
                     ovf      <= ovf_int_q;
                     bcd      <= dd_bcd_d;
                  end
               end
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
